// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM bundle: the ID/EX register contents going into the execute stage,
// the EX/MEM register contents coming out of it, and the upstream stall.
interface ex_mem_stage_if;
  logic        in_valid;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [3:0]  ex_in;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] sign_extend;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic        stall;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  write_reg;
  logic        zero;

  // Upstream pipeline side: drives ID/EX, consumes EX/MEM and stall.
  modport master (
    output in_valid, wb_in, m_in, ex_in, reg1, reg2, sign_extend, funct, rt, rd,
    input  stall, ex_wb, ex_m, alu_result, store_data, write_reg, zero
  );

  // Execute stage side.
  modport slave (
    input  in_valid, wb_in, m_in, ex_in, reg1, reg2, sign_extend, funct, rt, rd,
    output stall, ex_wb, ex_m, alu_result, store_data, write_reg, zero
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register. Single-cycle ALU ops complete in one
// clock; mult runs a 32-iteration shift-add sequence while stalling the front end.
module ex_mem_stage (
  input  logic          clk,
  input  logic          rst,
  ex_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_acc;
  logic [31:0] mul_store;
  logic [1:0]  mul_wb;
  logic [2:0]  mul_m;
  logic [4:0]  mul_dest;

  logic [31:0] op_b;
  logic [4:0]  dest;
  logic [31:0] alu_res;
  logic        is_mult;

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    op_b    = bus.ex_in[0] ? bus.sign_extend : bus.reg2;
    dest    = bus.ex_in[3] ? bus.rd : bus.rt;
    alu_res = '0;
    case (bus.ex_in[2:1])
      2'b00: alu_res = bus.reg1 + op_b;
      2'b01: alu_res = bus.reg1 - op_b;
      2'b11: alu_res = bus.reg1 | op_b;
      default: begin
        case (bus.funct)
          FN_ADD:  alu_res = bus.reg1 + op_b;
          FN_SUB:  alu_res = bus.reg1 - op_b;
          FN_AND:  alu_res = bus.reg1 & op_b;
          FN_OR:   alu_res = bus.reg1 | op_b;
          FN_SLT:  alu_res = {31'd0, $signed(bus.reg1) < $signed(op_b)};
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  assign is_mult   = bus.in_valid && (bus.ex_in[2:1] == 2'b10) && (bus.funct == FN_MULT);
  assign bus.stall = ((state == IDLE) && is_mult) || (state == BUSY);

  // NOTE: state and pipeline outputs use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.ex_wb      <= '0;
      bus.ex_m       <= '0;
      bus.alu_result <= '0;
      bus.store_data <= '0;
      bus.write_reg  <= '0;
      bus.zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mult) begin
            state          <= BUSY;
            cnt            <= '0;
            mul_a          <= bus.reg1;
            mul_b          <= op_b;
            mul_acc        <= '0;
            mul_store      <= bus.reg2;
            mul_wb         <= bus.wb_in;
            mul_m          <= bus.m_in;
            mul_dest       <= dest;
            bus.ex_wb      <= '0;
            bus.ex_m       <= '0;
          end else if (bus.in_valid) begin
            bus.ex_wb      <= bus.wb_in;
            bus.ex_m       <= bus.m_in;
            bus.alu_result <= alu_res;
            bus.store_data <= bus.reg2;
            bus.write_reg  <= dest;
            bus.zero       <= (alu_res == '0);
          end else begin
            bus.ex_wb      <= '0;
            bus.ex_m       <= '0;
            bus.alu_result <= '0;
            bus.store_data <= '0;
            bus.write_reg  <= '0;
            bus.zero       <= 1'b0;
          end
        end

        BUSY: begin
          // Low 32 bits of a two's-complement product equal the unsigned product's.
          if (mul_b[0]) mul_acc <= mul_acc + mul_a;
          mul_a     <= mul_a << 1;
          mul_b     <= mul_b >> 1;
          cnt       <= cnt + 5'd1;
          bus.ex_wb <= '0;
          bus.ex_m  <= '0;
          if (cnt == 5'd31) state <= DONE;
        end

        DONE: begin
          bus.ex_wb      <= mul_wb;
          bus.ex_m       <= mul_m;
          bus.alu_result <= mul_acc;
          bus.store_data <= mul_store;
          bus.write_reg  <= mul_dest;
          bus.zero       <= (mul_acc == '0);
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the multiplier datapath registers carry no reset; they are always loaded
  // at mult accept before being read, so only control state needs clearing.

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: single-cycle ALU ops, bubbles,
// multi-cycle mult timing, and reset abort of an in-flight mult.
module tb_ex_mem_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] se, input logic [5:0] fn,
                       input logic [4:0] rt, input logic [4:0] rd);
    bus.in_valid    = v;
    bus.wb_in       = wb;
    bus.m_in        = m;
    bus.ex_in       = ex;
    bus.reg1        = a;
    bus.reg2        = r2;
    bus.sign_extend = se;
    bus.funct       = fn;
    bus.rt          = rt;
    bus.rd          = rd;
  endtask

  // Called in the accept cycle with the mult already on the inputs. Returns after the
  // first cycle with stall low (DONE), counting stall-high cycles including accept.
  task automatic run_mult(output int stall_cycles, output logic bubbles_ok);
    stall_cycles = bus.stall ? 1 : 0;
    bubbles_ok   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.stall) break;
      stall_cycles++;
      if (bus.ex_wb != 2'd0 || bus.ex_m != 3'd0) bubbles_ok = 1'b0;
    end
  endtask

  int   n_stall;
  logic bub_ok;
  logic seen_product;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 2'd0, 3'd0, 4'd0, 32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 5'd0);
    tick();
    tick();
    check("rst_ex_wb",      {30'd0, bus.ex_wb}, 32'd0);
    check("rst_ex_m",       {29'd0, bus.ex_m},  32'd0);
    check("rst_alu_result", bus.alu_result,     32'd0);
    check("rst_store_data", bus.store_data,     32'd0);
    check("rst_write_reg",  {27'd0, bus.write_reg}, 32'd0);
    check("rst_zero",       {31'd0, bus.zero},  32'd0);
    rst = 1'b0;
    #1;
    check("rst_stall",      {31'd0, bus.stall}, 32'd0);

    // R-type add with wrap into the sign bit
    drive(1'b1, 2'b11, 3'b101, 4'b1100, 32'h7FFF_FFFF, 32'd1, 32'd0, 6'h20, 5'd3, 5'd5);
    tick();
    check("add_result",    bus.alu_result, 32'h8000_0000);
    check("add_write_reg", {27'd0, bus.write_reg}, 32'd5);
    check("add_zero",      {31'd0, bus.zero}, 32'd0);
    check("add_ex_wb",     {30'd0, bus.ex_wb}, 32'd3);
    check("add_ex_m",      {29'd0, bus.ex_m}, 32'd5);
    check("add_store",     bus.store_data, 32'd1);

    // Immediate sub to zero, destination rt
    drive(1'b1, 2'b01, 3'b010, 4'b0011, 32'd10, 32'h0000_1234, 32'd10, 6'h00, 5'd9, 5'd4);
    tick();
    check("sub_result",    bus.alu_result, 32'd0);
    check("sub_zero",      {31'd0, bus.zero}, 32'd1);
    check("sub_write_reg", {27'd0, bus.write_reg}, 32'd9);
    check("sub_store",     bus.store_data, 32'h0000_1234);

    // Signed slt: -1 < 1
    drive(1'b1, 2'b10, 3'b000, 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd0, 6'h2A, 5'd1, 5'd2);
    tick();
    check("slt_result", bus.alu_result, 32'd1);
    check("slt_zero",   {31'd0, bus.zero}, 32'd0);

    // R-type and
    drive(1'b1, 2'b10, 3'b000, 4'b1100, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 6'h24, 5'd1, 5'd2);
    tick();
    check("and_result", bus.alu_result, 32'h0000_F000);

    // ALUOp=11 or
    drive(1'b1, 2'b10, 3'b000, 4'b1110, 32'h0000_000F, 32'h0000_00F0, 32'd0, 6'h00, 5'd1, 5'd2);
    tick();
    check("or_result", bus.alu_result, 32'h0000_00FF);

    // Bubble with nonzero controls on the inputs
    drive(1'b0, 2'b11, 3'b111, 4'b1100, 32'd1, 32'd2, 32'd0, 6'h20, 5'd1, 5'd2);
    tick();
    check("bubble_ex_wb", {30'd0, bus.ex_wb}, 32'd0);
    check("bubble_ex_m",  {29'd0, bus.ex_m},  32'd0);

    // Unknown funct
    drive(1'b1, 2'b10, 3'b010, 4'b1100, 32'd5, 32'd6, 32'd0, 6'h3F, 5'd1, 5'd17);
    tick();
    check("unk_result",    bus.alu_result, 32'd0);
    check("unk_zero",      {31'd0, bus.zero}, 32'd1);
    check("unk_ex_wb",     {30'd0, bus.ex_wb}, 32'd2);
    check("unk_ex_m",      {29'd0, bus.ex_m}, 32'd2);
    check("unk_write_reg", {27'd0, bus.write_reg}, 32'd17);

    // mult -3 * 7, inputs held through DONE as the upstream would
    drive(1'b1, 2'b01, 3'b100, 4'b1100, 32'hFFFF_FFFD, 32'd7, 32'd0, 6'h18, 5'd3, 5'd12);
    #1;
    check("mult1_stall_accept", {31'd0, bus.stall}, 32'd1);
    run_mult(n_stall, bub_ok);
    check("mult1_stall_cycles", n_stall, 32'd33);
    check("mult1_busy_bubbles", {31'd0, bub_ok}, 32'd1);
    check("mult1_done_bubble",  {30'd0, bus.ex_wb}, 32'd0);
    tick();
    check("mult1_result",    bus.alu_result, 32'hFFFF_FFEB);
    check("mult1_ex_wb",     {30'd0, bus.ex_wb}, 32'd1);
    check("mult1_ex_m",      {29'd0, bus.ex_m}, 32'd4);
    check("mult1_write_reg", {27'd0, bus.write_reg}, 32'd12);
    check("mult1_zero",      {31'd0, bus.zero}, 32'd0);
    check("mult1_store",     bus.store_data, 32'd7);

    // Back-to-back mult: 6 * -2, accepted straight from IDLE
    drive(1'b1, 2'b10, 3'b001, 4'b1100, 32'd6, 32'hFFFF_FFFE, 32'd0, 6'h18, 5'd3, 5'd7);
    #1;
    check("mult2_stall_accept", {31'd0, bus.stall}, 32'd1);
    run_mult(n_stall, bub_ok);
    check("mult2_stall_cycles", n_stall, 32'd33);
    check("mult2_busy_bubbles", {31'd0, bub_ok}, 32'd1);
    tick();
    check("mult2_result",    bus.alu_result, 32'hFFFF_FFF4);
    check("mult2_ex_wb",     {30'd0, bus.ex_wb}, 32'd2);
    check("mult2_write_reg", {27'd0, bus.write_reg}, 32'd7);

    // mult aborted by reset in its 10th BUSY cycle
    drive(1'b1, 2'b11, 3'b111, 4'b1100, 32'd100, 32'd3, 32'd0, 6'h18, 5'd3, 5'd20);
    #1;
    repeat (10) tick();
    check("abort_busy_stall", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 2'd0, 3'd0, 4'd0, 32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_ex_wb",      {30'd0, bus.ex_wb}, 32'd0);
    check("abort_ex_m",       {29'd0, bus.ex_m}, 32'd0);
    check("abort_alu_result", bus.alu_result, 32'd0);
    check("abort_write_reg",  {27'd0, bus.write_reg}, 32'd0);
    check("abort_zero",       {31'd0, bus.zero}, 32'd0);
    check("abort_stall",      {31'd0, bus.stall}, 32'd0);
    seen_product = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ex_wb != 2'd0 || bus.alu_result == 32'd300 || bus.stall) seen_product = 1'b1;
    end
    check("abort_no_product", {31'd0, seen_product}, 32'd0);

    // Normal add after the abort
    drive(1'b1, 2'b10, 3'b011, 4'b1100, 32'd2, 32'd3, 32'd0, 6'h20, 5'd1, 5'd6);
    tick();
    check("post_add_result",    bus.alu_result, 32'd5);
    check("post_add_ex_wb",     {30'd0, bus.ex_wb}, 32'd2);
    check("post_add_write_reg", {27'd0, bus.write_reg}, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
